// File: rtl/nonogram_pkg.sv
// Shared types and sizing constants for the nonogram solver datapath.
package nonogram_pkg;

  // Ownership phase of the shared option FIFO across one puzzle.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CYCLE = 2'd1,
    FLUSH = 2'd2
  } fifo_phase_t;

  localparam int OPTION_W  = 16;
  localparam int MAX_ROWS  = 11;
  localparam int MAX_COLS  = 11;
  localparam int MAX_LINES = MAX_ROWS + MAX_COLS;

endpackage

// File: rtl/occ_counter.sv
// Up/down word counter for the option FIFO with synchronous clear.
// Build macro LINE_FIFO_HWM_EN adds a high-water mark of the count.
module occ_counter
  import nonogram_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] count
`ifdef LINE_FIFO_HWM_EN
  ,
  output logic [OCC_W-1:0] hwm
`endif
);

  logic [OCC_W-1:0] count_reg;
  logic [OCC_W-1:0] count_next;

  // A simultaneous increment and decrement cancel out.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec) begin
      count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Occupancy register; clear overrides any pending update.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

`ifdef LINE_FIFO_HWM_EN
  logic [OCC_W-1:0] hwm_reg;

  // Track the peak count; lags the count by one cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      hwm_reg <= '0;
    end else if (count_reg > hwm_reg) begin
      hwm_reg <= count_reg;
    end
  end

  assign hwm = hwm_reg;
`endif

endmodule

// File: rtl/line_fifo_ctrl.sv
// Owner/arbiter for the shared 16-bit option FIFO: parser fill, solver
// put-back and reads, pass counting and the inter-puzzle FIFO reset.
// Build macro LINE_FIFO_HWM_EN adds the hwm (peak occupancy) output.
module line_fifo_ctrl
  import nonogram_pkg::*;
#(
  parameter  int DATA_W       = OPTION_W,
  parameter  int DEPTH        = 1024,
  parameter  int MAX_LINES    = 22,
  parameter  int FLUSH_CYCLES = 4,
  localparam int OCC_W        = $clog2(DEPTH + 1),
  localparam int LINE_W       = $clog2(MAX_LINES + 1),
  localparam int FC_W         = $clog2(FLUSH_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              board_parsed,
  input  logic              board_solved,
  input  logic [LINE_W-1:0] num_lines,
  input  logic              p_valid,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              pass_done,
  output logic [OCC_W-1:0]  occupancy,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  output logic              fifo_srst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty
`ifdef LINE_FIFO_HWM_EN
  ,
  output logic [OCC_W-1:0]  hwm
`endif
);

  fifo_phase_t      phase_reg;
  logic [FC_W-1:0]  flush_cnt_reg;
  logic [LINE_W-1:0] lines_reg;
  logic [LINE_W-1:0] pass_cnt_reg;
  logic             rd_valid_reg;
  logic             pass_done_reg;
  logic [OCC_W-1:0] occ;
  logic             room;
  logic             flush_enter;
  logic             occ_clr;

  // A write needs both the IP's full flag and our own count to agree there is room.
  assign room        = !fifo_full && (occ != OCC_W'(DEPTH));
  assign p_ready     = (phase_reg == FILL)  && room;
  assign s_ready     = (phase_reg == CYCLE) && room;
  assign fifo_wr_en  = (p_valid && p_ready) || (s_valid && s_ready);
  assign fifo_rd_en  = (phase_reg == CYCLE) && rd_req && !fifo_empty;
  assign fifo_srst   = (phase_reg == FLUSH);
  assign flush_enter = (phase_reg == CYCLE) && board_solved;
  // Clearing on the entry edge makes occupancy read 0 throughout FLUSH.
  assign occ_clr     = rst || (phase_reg == FLUSH) || flush_enter;

  // Write data follows whichever side owns the port in this phase.
  always_comb begin
    fifo_din = '0;
    case (phase_reg)
      FILL:    fifo_din = p_data;
      CYCLE:   fifo_din = s_data;
      default: fifo_din = '0;
    endcase
  end

  // Phase sequencer: fill, solve, then hold the FIFO in reset for a fixed time.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg     <= FLUSH;
      flush_cnt_reg <= '0;
      lines_reg     <= '0;
    end else begin
      case (phase_reg)
        FILL: begin
          if (board_parsed) begin
            phase_reg <= CYCLE;
            lines_reg <= num_lines;
          end
        end
        CYCLE: begin
          if (board_solved) begin
            phase_reg     <= FLUSH;
            flush_cnt_reg <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FC_W'(FLUSH_CYCLES - 1)) begin
            phase_reg     <= FILL;
            flush_cnt_reg <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        default: phase_reg <= FLUSH;
      endcase
    end
  end

  // FIFO read latency is one cycle, so rd_valid is the delayed read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= fifo_rd_en;
    end
  end

  // Count reads in the current pass; wrap and flag after num_lines reads.
  always_ff @(posedge clk) begin
    if (rst || (phase_reg == FLUSH)) begin
      pass_cnt_reg  <= '0;
      pass_done_reg <= 1'b0;
    end else begin
      pass_done_reg <= 1'b0;
      if (fifo_rd_en && (lines_reg != '0)) begin
        if (pass_cnt_reg == lines_reg - 1'b1) begin
          pass_cnt_reg  <= '0;
          pass_done_reg <= 1'b1;
        end else begin
          pass_cnt_reg <= pass_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_valid_reg ? fifo_dout : '0;
  assign pass_done = pass_done_reg;

  occ_counter #(
    .DEPTH (DEPTH)
  ) u_occ (
    .clk   (clk),
    .clr   (occ_clr),
    .inc   (fifo_wr_en),
    .dec   (fifo_rd_en),
    .count (occ)
`ifdef LINE_FIFO_HWM_EN
    ,
    .hwm   (hwm)
`endif
  );

  assign occupancy = occ;

endmodule

// File: doc/line_fifo_ctrl.md
Name: line_fifo_ctrl

Overview:
Owns the single 16-bit option FIFO shared by the parser (fill writes), the solver (put-back writes and option reads) and the flush path after a solve.
- Arbitrates the FIFO write port between the two writers.
- Gates reads and tracks occupancy.
- Counts lines per solver pass.
- Sequences the FIFO synchronous reset between puzzles.
Sits between the parser/solver and the FIFO IP and replaces the ad-hoc write muxing in the top level.

Parameters:
DATA_W, 16, option/line word width
DEPTH, 1024, FIFO depth in words; occupancy counter width is $clog2(DEPTH+1)
MAX_LINES, 22, max rows+cols per puzzle (11+11)
FLUSH_CYCLES, 4, cycles fifo_srst is held during flush

Ports:
clk  in  1  system clock (50 MHz domain)
rst  in  1  synchronous active-high reset
board_parsed  in  1  pulse: parser finished the board (FILL->CYCLE)
board_solved  in  1  pulse: solver finished (CYCLE->FLUSH)
num_lines  in  $clog2(MAX_LINES+1)  rows+cols; sampled on board_parsed
p_valid  in  1  parser write request
p_data  in  DATA_W  parser write word
p_ready  out  1  parser write accepted this cycle
s_valid  in  1  solver put-back request
s_data  in  DATA_W  solver put-back word
s_ready  out  1  solver write accepted this cycle
rd_req  in  1  solver requests next option
rd_valid  out  1  rd_data valid (1 cycle after the accepted rd_req)
rd_data  out  DATA_W  option word
pass_done  out  1  pulse: num_lines new_line reads completed in this pass
occupancy  out  $clog2(DEPTH+1)  words currently in FIFO
fifo_din  out  DATA_W  to FIFO din
fifo_wr_en  out  1  to FIFO wr_en
fifo_rd_en  out  1  to FIFO rd_en
fifo_srst  out  1  to FIFO srst
fifo_dout  in  DATA_W  from FIFO dout
fifo_full  in  1  from FIFO full
fifo_empty  in  1  from FIFO empty

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- On rst, the FSM goes to FLUSH with its counter restarted. All outputs are 0, except fifo_srst, which is 1. Occupancy, pass counter and rd_valid are 0.
- FSM states are FILL, CYCLE and FLUSH.
  - FILL -> CYCLE on board_parsed; num_lines is latched.
  - CYCLE -> FLUSH on board_solved.
  - FLUSH -> FILL after FLUSH_CYCLES cycles.
- FILL:
  - Parser owns the write port. p_ready = !fifo_full && occupancy!=DEPTH.
  - s_ready=0. fifo_rd_en=0; rd_req is ignored.
- CYCLE:
  - Solver owns the write port. s_ready uses the same full rule as p_ready; p_ready=0.
  - fifo_rd_en = rd_req && !fifo_empty.
  - A read and a write in the same cycle are both allowed. A write at full is blocked even with a simultaneous read.
- FLUSH:
  - fifo_srst=1, p_ready=s_ready=0, fifo_rd_en=0.
  - occupancy forced to 0; pass counter cleared.
- Writes:
  - fifo_wr_en = (selected valid && selected ready). Combinational, zero added latency.
  - fifo_din muxed from the owner.
- Reads:
  - rd_valid registered: 1 exactly one cycle after fifo_rd_en.
  - rd_data = fifo_dout (FIFO read latency 1).
  - rd_req on empty produces no read and no rd_valid.
- Occupancy:
  - +1 on write only, -1 on read only, unchanged on both.
  - Never wraps: saturated by the ready/empty rules.
- Pass counter:
  - Counts accepted reads in CYCLE. When it reaches num_lines-1 and another read is accepted: pass_done pulses 1 cycle (aligned with rd_valid) and the counter returns to 0.
  - num_lines=0 means pass_done is never asserted.
- Simultaneous events:
  - board_parsed and board_solved in the same cycle: only the transition for the current state applies.
  - rst mid-operation always wins and re-enters FLUSH.

Optional Feature:
LINE_FIFO_HWM_EN
- With: adds output hwm[$clog2(DEPTH+1)-1:0], the maximum occupancy since the last FLUSH exit. Updated the cycle after occupancy changes; cleared in FLUSH/rst.
- Without: no port and no logic.

Decomposition:
- Package nonogram_pkg holds:
  - fifo_phase_t enum {FILL, CYCLE, FLUSH};
  - OPTION_W=16, MAX_ROWS=11, MAX_COLS=11, MAX_LINES.
- Sub-module occ_counter: up/down occupancy counter with sync clear and optional high-water mark.

Test Plan:
- Reset, then 4 idle cycles -> fifo_srst=1 for FLUSH_CYCLES=4 cycles, then FILL; p_ready=1, occupancy=0.
- FILL, p_valid with words 0x0001..0x0005 -> 5 fifo_wr_en pulses, occupancy=5; s_valid=1 throughout gives s_ready=0 and no solver writes.
- board_parsed with num_lines=3, then 3 rd_req -> rd_valid one cycle after each, data 0x0001..0x0003; pass_done pulses with the third rd_valid; occupancy=2.
- CYCLE, same-cycle rd_req and s_valid(0xABCD) at occupancy 2 -> occupancy stays 2; 0xABCD is read last.
- Fill to DEPTH with fifo_full=1 -> p_ready=0, no wr_en; rd_req on an empty FIFO gives fifo_rd_en=0, rd_valid=0.
- board_solved at occupancy 7, and rst asserted mid-CYCLE -> FLUSH; occupancy=0, fifo_srst for 4 cycles, then FILL; hwm=7 before the flush when LINE_FIFO_HWM_EN is defined.
